// File: rtl/video_text_gen.sv
// Text-mode raster generator: sweeps hcnt/vcnt, fetches character codes and glyph rows
// through a three-stage pipeline, and emits a 1-bit pixel with aligned sync/active.
module video_text_gen #(
  parameter int H_ACTIVE = 256,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 256,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int COLS     = 32,
  parameter int ROWS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] cg_addr,
  input  logic [7:0]  cg_data,
  output logic        pix,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters keep at least 8 bits so the row/col slices below always exist.
  localparam int HW    = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW    = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  typedef logic [HW-1:0] hcnt_t;
  typedef logic [VW-1:0] vcnt_t;

  localparam hcnt_t H_LAST = hcnt_t'(H_TOTAL - 1);
  localparam hcnt_t H_ACT  = hcnt_t'(H_ACTIVE);
  localparam hcnt_t HS_BEG = hcnt_t'(H_ACTIVE + H_FP);
  localparam hcnt_t HS_END = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t V_ACT  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t VS_BEG = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } tmg_t;

  localparam tmg_t TMG_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  hcnt_t           hcnt;
  vcnt_t           vcnt;
  tmg_t            tmg0;
  tmg_t [2:1]      tmg_pipe;
  logic [2:0]      h1, v1, h2;
  logic            h_wrap, v_wrap;

  always_comb begin
    h_wrap   = (hcnt == H_LAST);
    v_wrap   = (vcnt == V_LAST);
    tmg0.act = (hcnt < H_ACT) && (vcnt < V_ACT);
    tmg0.hs  = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    tmg0.vs  = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt      <= '0;
      vcnt      <= '0;
      vram_addr <= '0;
      cg_addr   <= '0;
      h1        <= '0;
      v1        <= '0;
      h2        <= '0;
      tmg_pipe  <= {TMG_IDLE, TMG_IDLE};
      pix       <= 1'b0;
      active    <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      frame     <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (pix_en) begin
        hcnt  <= h_wrap ? '0 : hcnt + hcnt_t'(1);
        if (h_wrap)
          vcnt <= v_wrap ? '0 : vcnt + vcnt_t'(1);
        frame <= h_wrap && v_wrap;
        // stage 1: character fetch, addressed even in blanking
        vram_addr <= {vcnt[3 +: ROW_W], hcnt[3 +: COL_W]};
        h1        <= hcnt[2:0];
        v1        <= vcnt[2:0];
        tmg_pipe  <= {tmg_pipe[1], tmg0};
        // stage 2: glyph row fetch
        cg_addr   <= {vram_data, v1};
        h2        <= h1;
        // stage 3: serialize, bit 7 is leftmost
        pix       <= tmg_pipe[2].act & cg_data[3'd7 - h2];
        active    <= tmg_pipe[2].act;
        hsync     <= tmg_pipe[2].hs;
        vsync     <= tmg_pipe[2].vs;
      end
    end
  end

endmodule

// File: tb/tb_video_text_gen.sv
// Bench for video_text_gen on a reduced raster; every pix_en edge is checked against
// a position-based model of the raster computed from the edge count since reset.
module tb_video_text_gen;

  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] cg_addr;
  logic [7:0]  cg_data;
  logic        pix, active, hsync, vsync, frame;

  logic [7:0] vram [1024];
  logic [7:0] rom  [2048];
  int n, vec, errs;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    cg_data   <= rom[cg_addr];
  end

  video_text_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .cg_addr(cg_addr), .cg_data(cg_data),
    .pix(pix), .active(active), .hsync(hsync), .vsync(vsync), .frame(frame)
  );

  // Text cell address of raster position q (q counted from the top-left pixel).
  function automatic int addr_of(input int q);
    int x, y;
    x = q % HT;
    y = q / HT;
    return ((y / 8) % 32) * 32 + (x / 8) % 32;
  endfunction

  // Expected {pix, active, hsync, vsync, frame} right after the k-th pix_en edge.
  function automatic logic [4:0] exp_out(input int k);
    int p, x, y, idx;
    logic a, h, v, px, fr;
    logic [7:0] gl;
    if (k < 3) return 5'b00110;
    p   = (k - 3) % FRAME;
    x   = p % HT;
    y   = p / HT;
    a   = (x < HA) && (y < VA);
    h   = !((x >= HA + HFP) && (x < HA + HFP + HSW));
    v   = !((y >= VA + VFP) && (y < VA + VFP + VSW));
    idx = int'(vram[addr_of(p)]) * 8 + y % 8;
    gl  = rom[idx];
    px  = a && gl[7 - x % 8];
    fr  = (k % FRAME) == 0;
    return {px, a, h, v, fr};
  endfunction

  function automatic logic [9:0] exp_va(input int k);
    return 10'(addr_of((k - 1) % FRAME));
  endfunction

  function automatic logic [10:0] exp_cg(input int k);
    int q;
    q = (k - 2) % FRAME;
    return 11'(int'(vram[addr_of(q)]) * 8 + (q / HT) % 8);
  endfunction

  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clk);
    #1 pix_en = 1'b0;
    if (en) n++;
  endtask

  task automatic adv(input int k);
    for (int i = 0; i < k; i++) begin
      tick(1'b1);
      tick(1'b0);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_en = i[0];
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    pix_en = 1'b0;
    n      = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [4:0] o, e;
    fill_random();
    apply_reset();
    adv(150);
    reset  = 1'b1;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    vec++; if (pix !== 1'b0)       begin errs++; $display("FAIL reset_pix got %b want 0", pix); end
    vec++; if (active !== 1'b0)    begin errs++; $display("FAIL reset_active got %b want 0", active); end
    vec++; if (hsync !== 1'b1)     begin errs++; $display("FAIL reset_hsync got %b want 1", hsync); end
    vec++; if (vsync !== 1'b1)     begin errs++; $display("FAIL reset_vsync got %b want 1", vsync); end
    vec++; if (frame !== 1'b0)     begin errs++; $display("FAIL reset_frame got %b want 0", frame); end
    vec++; if (vram_addr !== 10'd0) begin errs++; $display("FAIL reset_vram_addr got %h want 000", vram_addr); end
    vec++; if (cg_addr !== 11'd0)  begin errs++; $display("FAIL reset_cg_addr got %h want 000", cg_addr); end
    pix_en = 1'b0;
    @(posedge clk);
    #1 pix_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    pix_en = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      o = {pix, active, hsync, vsync, frame};
      e = exp_out(n);
      vec++; if (o !== e) begin errs++; $display("FAIL post_reset edge=%0d got %b want %b", n, o, e); end
      tick(1'b0);
    end
  endtask

  task automatic test_raster();
    logic [4:0] o, e;
    logic p_hs, p_vs, p_act;
    int hs_fall, hs_low, vs_low, act_run, act_lines, fr_last;
    fill_random();
    apply_reset();
    p_hs = 1'b1; p_vs = 1'b1; p_act = 1'b0;
    hs_fall = -1; hs_low = 0; vs_low = 0; act_run = 0; act_lines = 0; fr_last = -1;
    for (int i = 0; i < 2 * FRAME + HT; i++) begin
      tick(1'b1);
      o = {pix, active, hsync, vsync, frame};
      e = exp_out(n);
      vec++; if (o !== e) begin errs++; $display("FAIL raster edge=%0d got %b want %b", n, o, e); end
      vec++; if (vram_addr !== exp_va(n)) begin errs++; $display("FAIL vram_addr edge=%0d got %h want %h", n, vram_addr, exp_va(n)); end
      if (n >= 2) begin
        vec++; if (cg_addr !== exp_cg(n)) begin errs++; $display("FAIL cg_addr edge=%0d got %h want %h", n, cg_addr, exp_cg(n)); end
      end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (active) act_run++;
      if (p_hs && !hsync) begin
        if (hs_fall >= 0) begin
          vec++; if (n - hs_fall !== HT) begin errs++; $display("FAIL hsync_period got %0d want %0d", n - hs_fall, HT); end
        end
        hs_fall = n;
      end
      if (!p_hs && hsync) begin
        vec++; if (hs_low !== HSW) begin errs++; $display("FAIL hsync_width got %0d want %0d", hs_low, HSW); end
        hs_low = 0;
      end
      if (p_act && !active) begin
        vec++; if (act_run !== HA) begin errs++; $display("FAIL active_width got %0d want %0d", act_run, HA); end
        act_run = 0;
        act_lines++;
      end
      if (p_vs && !vsync) begin
        vec++; if (act_lines !== VA) begin errs++; $display("FAIL active_lines got %0d want %0d", act_lines, VA); end
        act_lines = 0;
      end
      if (!p_vs && vsync) begin
        vec++; if (vs_low !== VSW * HT) begin errs++; $display("FAIL vsync_width got %0d want %0d", vs_low, VSW * HT); end
        vs_low = 0;
      end
      if (frame) begin
        if (fr_last >= 0) begin
          vec++; if (n - fr_last !== FRAME) begin errs++; $display("FAIL frame_period got %0d want %0d", n - fr_last, FRAME); end
        end
        fr_last = n;
      end
      p_hs = hsync; p_vs = vsync; p_act = active;
      tick(1'b0);
      vec++; if (frame !== 1'b0) begin errs++; $display("FAIL frame_clear edge=%0d got %b want 0", n, frame); end
    end
    vec++; if (fr_last !== 2 * FRAME) begin errs++; $display("FAIL last_frame_edge got %0d want %0d", fr_last, 2 * FRAME); end
  endtask

  task automatic test_addressing();
    fill_random();
    vram[10'h025] = 8'h7E;
    apply_reset();
    adv(9 * HT + 40);
    tick(1'b1);
    vec++; if (vram_addr !== 10'h025) begin errs++; $display("FAIL addr_vram got %h want 025", vram_addr); end
    tick(1'b0);
    tick(1'b1);
    vec++; if (cg_addr !== 11'h3F1) begin errs++; $display("FAIL addr_cg got %h want 3f1", cg_addr); end
    tick(1'b0);
  endtask

  task automatic test_glyph();
    int exp_pix [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    fill_random();
    vram[0]      = 8'h41;
    rom[11'h208] = 8'hA5;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      vec++; if ({active, pix} !== 2'b00) begin errs++; $display("FAIL glyph_lead edge=%0d got act=%b pix=%b want 0 0", n, active, pix); end
      tick(1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1);
      vec++; if (active !== 1'b1 || pix !== 1'(exp_pix[i])) begin
        errs++; $display("FAIL glyph_px%0d got act=%b pix=%b want 1 %0d", i, active, pix, exp_pix[i]);
      end
      tick(1'b0);
    end
  endtask

  task automatic test_blanking();
    int lit;
    fill_random();
    for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
    apply_reset();
    lit = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick(1'b1);
      vec++; if (pix !== active) begin errs++; $display("FAIL blank edge=%0d got pix=%b want %b", n, pix, active); end
      if (pix) lit++;
      tick(1'b0);
    end
    vec++; if (lit !== HA * VA) begin errs++; $display("FAIL blank_lit got %0d want %0d", lit, HA * VA); end
  endtask

  task automatic test_stall();
    logic [4:0] o, e;
    fill_random();
    apply_reset();
    adv(100);
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      o = {pix, active, hsync, vsync, frame};
      e = exp_out(n) & 5'b11110;
      vec++; if (o !== e || vram_addr !== exp_va(n) || cg_addr !== exp_cg(n)) begin
        errs++; $display("FAIL stall clk=%0d got %b %h %h want %b %h %h", i, o, vram_addr, cg_addr, e, exp_va(n), exp_cg(n));
      end
    end
    for (int i = 0; i < 300; i++) begin
      tick(1'b1);
      o = {pix, active, hsync, vsync, frame};
      e = exp_out(n);
      vec++; if (o !== e) begin errs++; $display("FAIL resume edge=%0d got %b want %b", n, o, e); end
      tick(1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    fill_random();
    apply_reset();
    adv(FRAME / 2 + 37);
    apply_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      vec++; if (frame !== (n == FRAME)) begin errs++; $display("FAIL midframe_frame edge=%0d got %b want %b", n, frame, n == FRAME); end
      tick(1'b0);
    end
  endtask

  initial begin
    n = 0; vec = 0; errs = 0;
    test_reset();
    test_raster();
    test_addressing();
    test_glyph();
    test_blanking();
    test_stall();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/video_text_gen.md
# video_text_gen

Text-mode video timing and pixel generator. It sweeps a raster, fetches each character code from video RAM, and looks up the glyph row in the 2 kB character-generator ROM (256 glyphs × 8 rows × 8 pixels). It then serializes the glyph to a 1-bit pixel stream with matched hsync/vsync/active. It is the read side of the character-generator ROM and video RAM, and drives the video output stage.

## Interface

Parameters:
- H_ACTIVE, 256: active pixels per line; must equal 8 × COLS.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 32: hsync width, in pixels.
- H_BP, 16: horizontal back porch, in pixels. H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 320.
- V_ACTIVE, 256: active lines per frame; must equal 8 × ROWS.
- V_FP, 8: vertical front porch, in lines.
- V_SYNC, 4: vsync width, in lines.
- V_BP, 12: vertical back porch, in lines. V_TOTAL = 280.
- COLS, 32 / ROWS, 32: text grid size; fixed at 32 × 32 (10-bit video RAM address).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate clock enable; asserted at most every other clk
- vram_addr  out  10  video RAM address, {row[4:0], col[4:0]}
- vram_data  in  8  character code; synchronous RAM, valid 1 clk after vram_addr
- cg_addr  out  11  CG ROM address, {char[7:0], glyph_row[2:0]}
- cg_data  in  8  glyph row; synchronous ROM, valid 1 clk after cg_addr; bit 7 = leftmost pixel
- pix  out  1  pixel (1 = lit)
- active  out  1  pixel is inside the active area
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- frame  out  1  one-clk pulse on the pix_en edge where the counters wrap to (0,0)

## Operation

- All state advances only on clk edges with pix_en=1. The only exception is `frame`, which is cleared on the next clk.
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- Raw timing, stage 0, combinational from the counters:
  - act0 = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
  - hs0 = 0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else 1.
  - vs0 = 0 for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), else 1.
- Stage 1 register, on pix_en:
  - vram_addr <= {vcnt[7:3], hcnt[7:3]}.
  - Carry alongside: h1 = hcnt[2:0], v1 = vcnt[2:0], act1, hs1, vs1.
- Stage 2 register, on pix_en:
  - cg_addr <= {vram_data, v1}.
  - Carry alongside: h2, act2, hs2, vs2.
- Stage 3 register, on pix_en:
  - pix <= act2 & cg_data[7 − h2].
  - active <= act2, hsync <= hs2, vsync <= vs2.
- Blanking: vram_addr is computed from the counters even during blanking. Reads during blanking are harmless, and pix is forced to 0 there.
- Reset, including mid-frame, takes effect on the next clk regardless of pix_en. Reset values:
  - hcnt, vcnt, vram_addr, cg_addr: 0.
  - All carried pipeline bits: inactive (act=0, hs=vs=1).
  - pix=0, active=0, hsync=1, vsync=1, frame=0.
- Because of the reset values, the first 3 pix_en edges after reset emit blank, non-sync outputs.

## Timing

- Latency: the outputs for position (x,y) appear on the 3rd pix_en edge after the edge that loaded hcnt=x, vcnt=y. Sync and active carry the same 3-edge delay, so they stay aligned with pix.
- pix_en spacing of at least 2 clk is required. This guarantees vram_data and cg_data have settled before the next stage samples them. Consecutive pix_en behaviour is unspecified.
- One line is H_TOTAL pix_en edges. One frame is H_TOTAL × V_TOTAL = 89600 pix_en edges.
- hsync low for H_SYNC edges per line. vsync low for V_SYNC × H_TOTAL edges per frame.
- frame asserts for exactly 1 clk, once per frame.
- All outputs are registered, with no combinational path from input to output.
- Stall (pix_en=0 for any duration): every output holds its value and frame stays 0.

## Test plan

- Reset: assert reset for 3 clk mid-line with pix_en toggling.
  - Next clk: pix=0, active=0, hsync=1, vsync=1, vram_addr=0, cg_addr=0, frame=0.
  - First 3 pix_en edges after release: still blank.
- Raster geometry, pix_en every 2nd clk, 2 frames:
  - 320 edges between hsync falls; hsync low for 32 edges.
  - Active runs 256 edges per line and 256 lines per frame.
  - vsync low for 1280 edges; frame pulse every 89600 edges.
- Addressing: when counters are at hcnt=40, vcnt=9, vram_addr=0x025 one edge later. With vram_data=0x7E, cg_addr=0x3F1 one edge after that.
- Glyph serialization: vram[0x000]=0x41, rom[0x208]=0xA5. The first 8 active pixels of line 0 are 1,0,1,0,0,1,0,1, in step with active rising.
- Blanking: ROM returns 0xFF everywhere → pix=1 only while active=1, and pix=0 throughout porches and sync.
- Stall and reset mid-operation:
  - Hold pix_en low for 50 clk mid-line → all outputs frozen, then the raster resumes exactly where it stopped.
  - Reset mid-frame → the next frame pulse arrives exactly 89600 edges after reset release.
